// File: rtl/serdes_pkg.sv
// Shared constants and state labels for the SerDes transmit serializer.
package serdes_pkg;

  localparam int DATA_W_DEFAULT = 64;
  localparam int CNT_W_DEFAULT  = 6;

  // Debug/waveform label only; the implemented state bit is `active`.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ser_shift_reg.sv
// Load/shift register feeding the serial line.
// Bit order: MSB first by default; define SERDES_LSB_FIRST_EN for LSB first.
module ser_shift_reg
  import serdes_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk_serial,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              line_bit
);

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;

  // Load wins over shift so a last-bit reload chains words with no gap.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift) begin
`ifdef SERDES_LSB_FIRST_EN
      shreg_d = shreg_q >> 1;
`else
      shreg_d = shreg_q << 1;
`endif
    end
  end

  // Register update; reset clears any partially sent word.
  always_ff @(posedge clk_serial or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

`ifdef SERDES_LSB_FIRST_EN
  assign line_bit = shreg_q[0];
`else
  assign line_bit = shreg_q[DATA_W-1];
`endif

endmodule

// File: rtl/serializer_64to1_serdes.sv
// Parallel-to-serial transmit stage: one DATA_W word per valid/ready
// handshake, one bit per clk_serial cycle, back-to-back with no gap bit.
// Optional macro SERDES_LSB_FIRST_EN selects LSB-first line order.
module serializer_64to1_serdes
  import serdes_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk_serial,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              serial_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             active;
  logic             active_d;
  logic             last_bit;
  logic             accept;
  logic             line_bit;
  ser_state_e       state;

  assign state    = active ? SHIFT : IDLE;
  assign last_bit = (cnt_q == CNT_LAST);

  // Ready while idle, or on the final bit of the current word.
  assign ready_out = ~active | (active & last_bit);
  assign accept    = valid_in & ready_out;

  // Bit counter and active flag; an accept always restarts the word.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active;
    if (accept) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active) begin
      if (last_bit) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Control state; asynchronous reset abandons any word in flight.
  always_ff @(posedge clk_serial or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      active <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      active <= active_d;
    end
  end

  ser_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk_serial (clk_serial),
    .rst_n      (rst_n),
    .load       (accept),
    .shift      (active & ~accept),
    .load_data  (data_in),
    .line_bit   (line_bit)
  );

  // Idle line is held low.
  assign serial_out = (state == SHIFT) ? line_bit : 1'b0;

endmodule

// File: tb/tb_serializer_64to1_serdes.sv
// Self-checking bench for serializer_64to1_serdes.
module tb_serializer_64to1_serdes;

  logic        clk_serial;
  logic        rst_n;
  logic [63:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        serial_out;

  int checks = 0;
  int errors = 0;

  serializer_64to1_serdes dut (
    .clk_serial (clk_serial),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .serial_out (serial_out)
  );

  initial clk_serial = 1'b0;
  always #5 clk_serial = ~clk_serial;

  typedef struct {
    logic [63:0] word;
    logic [63:0] exp_word;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] shift_in(input logic [63:0] c, input logic b);
`ifdef SERDES_LSB_FIRST_EN
    return {b, c[63:1]};
`else
    return {c[62:0], b};
`endif
  endfunction

  // Wait (bounded) for ready at a negedge, present the word, return at the
  // negedge after the accept edge (cycle 1 of the word).
  task automatic send(input logic [63:0] w);
    int t;
    t = 0;
    while (!ready_out && t < 200) begin
      @(negedge clk_serial);
      t++;
    end
    if (t >= 200) chk("send_ready_timeout", 64'(t), 64'd0);
    valid_in = 1'b1;
    data_in  = w;
    @(negedge clk_serial);
    valid_in = 1'b0;
    data_in  = 64'h0123_4567_89AB_CDEF;
  endtask

  // Collect bits while active; optionally raise valid_in for one cycle at inject_at.
  task automatic capture(input int inject_at, output logic [63:0] cap, output int n,
                         output logic first_b, output logic last_b);
    int c;
    cap = '0;
    c = 1;
    first_b = 1'b0;
    last_b  = 1'b0;
    while (dut.active && c <= 200) begin
      cap = shift_in(cap, serial_out);
      if (c == 1) first_b = serial_out;
      last_b = serial_out;
      if (c == inject_at) begin
        chk("ready_low_midword", 64'(ready_out), 64'd0);
        valid_in = 1'b1;
        data_in  = 64'hFFFF_0000_FFFF_0000;
      end
      if (c == inject_at + 1) valid_in = 1'b0;
      @(negedge clk_serial);
      c++;
    end
    n = c - 1;
  endtask

  initial begin
    logic [63:0] cap, capa, capb;
    int          n, act_err, rdy_err;
    logic        fb, lb;

    vecs[0] = '{64'hAAAABBBB_12345678, 64'hAAAABBBB_12345678, 64};
    vecs[1] = '{64'hAAAABBBB_0F1E2D3C, 64'hAAAABBBB_0F1E2D3C, 64};
    vecs[2] = '{64'hAAAABBBB_DEADBEEF, 64'hAAAABBBB_DEADBEEF, 64};
    vecs[3] = '{64'hAAAABBBB_00000001, 64'hAAAABBBB_00000001, 64};
    vecs[4] = '{64'hAAAABBBB_80000000, 64'hAAAABBBB_80000000, 64};
    vecs[5] = '{64'hAAAABBBB_5A5AA5A5, 64'hAAAABBBB_5A5AA5A5, 64};
    vecs[6] = '{64'h00000000_00000000, 64'h00000000_00000000, 64};
    vecs[7] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64};

    // Reset held for two cycles
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (2) @(negedge clk_serial);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_serial", 64'(serial_out), 64'd0);
    chk("rst_active", 64'(dut.active), 64'd0);
    rst_n = 1'b1;
    act_err = 0;
    repeat (3) begin
      @(negedge clk_serial);
      if (dut.active || serial_out || !ready_out) act_err++;
    end
    chk("idle_after_release", 64'(act_err), 64'd0);

    // Table of isolated words
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].word);
      capture(-1, cap, n, fb, lb);
      chk($sformatf("word%0d_data", i), cap, vecs[i].exp_word);
      chk($sformatf("word%0d_cycles", i), 64'(n), 64'(vecs[i].exp_cycles));
      chk($sformatf("word%0d_idle_ready", i), 64'(ready_out), 64'd1);
      chk($sformatf("word%0d_idle_serial", i), 64'(serial_out), 64'd0);
    end

    // Back-to-back: valid held high across two words
    @(negedge clk_serial);
    valid_in = 1'b1;
    data_in  = 64'h1122_3344_5566_7788;
    @(negedge clk_serial);
    data_in  = 64'hDEAD_DEAD_DEAD_DEAD;
    capa = '0;
    capb = '0;
    act_err = 0;
    rdy_err = 0;
    for (int c = 1; c <= 128; c++) begin
      if (!dut.active) act_err++;
      if (ready_out !== ((c % 64) == 0)) rdy_err++;
      if (c <= 64) capa = shift_in(capa, serial_out);
      else         capb = shift_in(capb, serial_out);
      if (c == 64)  data_in = 64'hCAFE_F00D_0BAD_BEEF;
      if (c == 128) valid_in = 1'b0;
      @(negedge clk_serial);
    end
    chk("b2b_active_gaps", 64'(act_err), 64'd0);
    chk("b2b_ready_pattern", 64'(rdy_err), 64'd0);
    chk("b2b_word0", capa, 64'h1122_3344_5566_7788);
    chk("b2b_word1", capb, 64'hCAFE_F00D_0BAD_BEEF);
    chk("b2b_end_active", 64'(dut.active), 64'd0);

    // valid_in raised mid-word at cycle 10 is ignored
    send(64'h0F0F_1234_A5A5_9876);
    capture(10, cap, n, fb, lb);
    chk("midvalid_data", cap, 64'h0F0F_1234_A5A5_9876);
    chk("midvalid_cycles", 64'(n), 64'd64);
    chk("midvalid_idle_active", 64'(dut.active), 64'd0);

    // Asynchronous reset at bit 30
    send(64'h7777_8888_9999_AAAA);
    repeat (29) @(negedge clk_serial);
    chk("pre_rst_active", 64'(dut.active), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_active", 64'(dut.active), 64'd0);
    chk("async_rst_serial", 64'(serial_out), 64'd0);
    chk("async_rst_ready", 64'(ready_out), 64'd1);
    @(negedge clk_serial);
    rst_n = 1'b1;
    @(negedge clk_serial);
    chk("post_rst_idle", 64'(dut.active), 64'd0);
    send(64'h8000_0000_0000_0001);
    capture(-1, cap, n, fb, lb);
    chk("post_rst_data", cap, 64'h8000_0000_0000_0001);
    chk("post_rst_cycles", 64'(n), 64'd64);
    chk("post_rst_first_bit", 64'(fb), 64'd1);
    chk("post_rst_last_bit", 64'(lb), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer_64to1_serdes.md
# serializer_64to1_serdes

Parallel-to-serial transmit stage of the SerDes path. It accepts one 64-bit word per valid/ready handshake and shifts it out one bit per `clk_serial` cycle, MSB first by default. It supports back-to-back words with no idle gap. It sits between the word-level framing logic and the serial line driver.

## Interface
Parameters:
- `DATA_W`, default 64: word width; must be a power of two, at least 2.
- `CNT_W`, default `$clog2(DATA_W)` (6): bit-counter width.

Ports:
- `clk_serial`, input, 1: serial bit clock. The block's only clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `data_in`, input, `DATA_W`: parallel word. Sampled only on an accept edge.
- `valid_in`, input, 1: `data_in` is valid.
- `ready_out`, output, 1: the block can accept a word on this edge.
- `serial_out`, output, 1: serial data bit.

Internal signal `active` (1 bit, register) must exist under exactly this name. Benches probe it hierarchically as the "bit on line" qualifier.

## Operation
- State: `shreg[DATA_W-1:0]`, `cnt[CNT_W-1:0]`, `active`.
- Two states:
  - IDLE: `active`=0.
  - SHIFT: `active`=1.
- `ready_out` is combinational: `~active | (active & cnt==DATA_W-1)`.
- Accept = `valid_in & ready_out` at a rising edge. On accept: `shreg<=data_in`, `cnt<=0`, `active<=1`.
- SHIFT without accept:
  - `shreg<=shreg<<1`, zero filled.
  - `cnt<=cnt+1`.
  - When `cnt==DATA_W-1` and there is no accept: `active<=0`, `cnt<=0`.
- Last-bit cycle with accept: reload as above. The next word follows immediately with no gap bit.
- `serial_out` is combinational: `active ? shreg[DATA_W-1] : 1'b0`. The idle line is 0.
- `valid_in` while not ready is ignored; the word is not queued. The sender must hold `valid_in` until it sees `ready_out`.
- `data_in` changes outside accept edges have no effect.
- Counter arithmetic is modulo 2^CNT_W. It never exceeds `DATA_W-1` by construction.

## Timing
- Reset (asynchronous assert, any time, including mid-word):
  - `shreg`=0, `cnt`=0, `active`=0.
  - Therefore `serial_out`=0 and `ready_out`=1.
  - A partially sent word is discarded.
- Latency: bit `DATA_W-1` of the accepted word appears on `serial_out` in the cycle immediately after the accept edge. The bench samples it at the next rising edge, qualified by `active`.
- A word occupies exactly `DATA_W` consecutive cycles with `active`=1. Bit k (MSB first) is valid in cycle k+1 after accept.
- Back-to-back throughput is one word every `DATA_W` cycles when `valid_in` is held high.
- Isolated words: `ready_out` is high for the whole IDLE period.

## Configuration
- `SERDES_LSB_FIRST_EN`:
  - Defined: load is unchanged; SHIFT uses `shreg>>1`, zero filled; `serial_out` is `shreg[0]`. Bit order on the line is LSB first.
  - Undefined (default): MSB first as described above.
- Handshake, latency and `active` timing are identical in both builds.

## Structure
- Package `serdes_pkg`: `DATA_W_DEFAULT`=64 and `CNT_W_DEFAULT`=6. It also holds a `ser_state_e` enum (IDLE, SHIFT) for debug and waveform labelling; `active` remains the implemented state bit.
- One sub-module is natural: `ser_shift_reg`, holding the `DATA_W` load/shift register with a direction selected by the macro. The top module keeps the counter, `active` and the handshake.

## Test plan
- Reset, then hold `rst_n`=0 for 2 cycles -> `ready_out`=1, `serial_out`=0, `active`=0. Release -> no change while `valid_in`=0.
- Single word `64'hAAAABBBB_12345678` -> `active` high for exactly 64 cycles. The 64 captured bits reassemble to `AAAABBBB12345678`. Then `ready_out`=1 and `serial_out`=0.
- Five words `{32'hAAAABBBB, random}`, each sent when ready -> five captures, each equal to its input word. No lost or duplicated bits.
- `valid_in` held high with a new word each accept -> 128 consecutive `active` cycles. `ready_out` is high only on the 64th cycle of each word. No gap bit.
- `valid_in`=1 mid-word, cycle 10 -> ignored; the current word completes unchanged.
- `rst_n` pulsed low at bit 30 -> `active`=0 and `serial_out`=0 immediately. The next word `64'h8000_0000_0000_0001` serializes correctly. With `SERDES_LSB_FIRST_EN` the first bit is 1 and the last bit is 1, in reversed order.
